// File: rtl/pwm_duty_ctrl.sv
// Duty-word controller for the LED dimmer's 4-bit PWM comparator.
// Two push-buttons step the duty up or down, with debounce and auto-repeat.
// A breathe switch overrides the buttons and ramps the duty between 0 and 15.
module pwm_duty_ctrl #(
  parameter int         CNT_W       = 26,
  parameter int         DB_CYCLES   = 500000,
  parameter int         RPT_DELAY   = 25000000,
  parameter int         RPT_PERIOD  = 5000000,
  parameter int         BRTH_PERIOD = 3125000,
  parameter logic [3:0] INIT_DUTY   = 4'd0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_up,
  input  logic       btn_dn,
  input  logic       breathe_en,
  output logic [3:0] duty_out,
  output logic       at_max,
  output logic       at_min,
  output logic       step_pulse,
  output logic       mode_breathe
);

  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    BR_UP  = 2'd1,
    BR_DN  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] RPT_FIRST = CNT_W'(RPT_DELAY);
  localparam logic [CNT_W-1:0] RPT_NEXT  = CNT_W'(RPT_PERIOD);
  localparam logic [CNT_W-1:0] BRTH_LAST = CNT_W'(BRTH_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Index 0 is the "up" button, index 1 the "down" button throughout.
  logic [1:0]       btn_raw;
  logic [1:0]       btn_meta;
  logic [1:0]       btn_sync;
  logic [1:0]       btn_acc;
  logic [1:0]       btn_acc_d;
  logic [1:0]       btn_rise;
  logic [1:0]       rpt_hit;
  logic [1:0]       btn_req;
  logic [1:0]       rpt_phase;
  logic [CNT_W-1:0] db_cnt   [2];
  logic [CNT_W-1:0] hold_cnt [2];

  logic             br_meta;
  logic             br_sync;
  logic [CNT_W-1:0] brth_cnt;
  logic             brth_tick;

  state_t           state;
  state_t           state_next;
  logic [3:0]       duty_next;

  assign btn_raw   = {btn_dn, btn_up};
  assign brth_tick = (brth_cnt == BRTH_LAST);
  assign at_max    = (duty_out == 4'd15);
  assign at_min    = (duty_out == 4'd0);

  // Two-flop synchronisers for both buttons and the breathe switch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_meta <= '0;
      btn_sync <= '0;
      br_meta  <= 1'b0;
      br_sync  <= 1'b0;
    end else begin
      btn_meta <= btn_raw;
      btn_sync <= btn_meta;
      br_meta  <= breathe_en;
      br_sync  <= br_meta;
    end
  end

  // Debounce: accept a new level only after it has differed for DB_CYCLES cycles in a row.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_acc   <= '0;
      btn_acc_d <= '0;
      for (int i = 0; i < 2; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      btn_acc_d <= btn_acc;
      for (int i = 0; i < 2; i++) begin
        if (btn_sync[i] == btn_acc[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          btn_acc[i] <= btn_sync[i];
          db_cnt[i]  <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_ONE;
        end
      end
    end
  end

  // Press edges and auto-repeat hits become step requests, honoured only in MANUAL.
  always_comb begin
    btn_rise = '0;
    rpt_hit  = '0;
    btn_req  = '0;
    for (int i = 0; i < 2; i++) begin
      btn_rise[i] = btn_acc[i] & ~btn_acc_d[i];
      rpt_hit[i]  = btn_acc[i] & (hold_cnt[i] != '0) &
                    (rpt_phase[i] ? (hold_cnt[i] == RPT_NEXT) : (hold_cnt[i] == RPT_FIRST));
      btn_req[i]  = (state == MANUAL) & (btn_rise[i] | rpt_hit[i]);
    end
  end

  // Hold counters measure time since the last request; zero means idle, so a button
  // still held on return from breathe never repeats until it is pressed afresh.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rpt_phase <= '0;
      for (int i = 0; i < 2; i++) begin
        hold_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if ((state != MANUAL) || !btn_acc[i]) begin
          hold_cnt[i]  <= '0;
          rpt_phase[i] <= 1'b0;
        end else if (btn_rise[i] || rpt_hit[i]) begin
          hold_cnt[i]  <= CNT_ONE;
          rpt_phase[i] <= rpt_hit[i];
        end else if (hold_cnt[i] != '0) begin
          hold_cnt[i] <= hold_cnt[i] + CNT_ONE;
        end
      end
    end
  end

  // Breathe timer restarts on every entry to breathe mode and wraps on each tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      brth_cnt <= '0;
    end else if ((state == MANUAL) || !br_sync || brth_tick) begin
      brth_cnt <= '0;
    end else begin
      brth_cnt <= brth_cnt + CNT_ONE;
    end
  end

  // Next-state and next-duty: saturating manual steps, or the bouncing breathe ramp.
  always_comb begin
    state_next = state;
    duty_next  = duty_out;
    case (state)
      MANUAL: begin
        if (br_sync) begin
          state_next = BR_UP;
        end else if (btn_req[0] && !btn_req[1] && (duty_out != 4'd15)) begin
          duty_next = duty_out + 4'd1;
        end else if (btn_req[1] && !btn_req[0] && (duty_out != 4'd0)) begin
          duty_next = duty_out - 4'd1;
        end
      end
      BR_UP: begin
        if (!br_sync) begin
          state_next = MANUAL;
        end else if (brth_tick) begin
          if (duty_out == 4'd15) begin
            state_next = BR_DN;
            duty_next  = 4'd14;
          end else begin
            duty_next = duty_out + 4'd1;
          end
        end
      end
      BR_DN: begin
        if (!br_sync) begin
          state_next = MANUAL;
        end else if (brth_tick) begin
          if (duty_out == 4'd0) begin
            state_next = BR_UP;
            duty_next  = 4'd1;
          end else begin
            duty_next = duty_out - 4'd1;
          end
        end
      end
      default: state_next = MANUAL;
    endcase
  end

  // State, duty and the registered status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= MANUAL;
      duty_out     <= INIT_DUTY;
      step_pulse   <= 1'b0;
      mode_breathe <= 1'b0;
    end else begin
      state        <= state_next;
      duty_out     <= duty_next;
      step_pulse   <= (duty_next != duty_out);
      mode_breathe <= (state_next != MANUAL);
    end
  end

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// Scoreboard bench for pwm_duty_ctrl using short timing parameters.
// Stimulus tasks plan the expected duty steps (edge number and value) into a queue;
// a monitor pops one entry for every step_pulse it sees.
module tb_pwm_duty_ctrl;

  localparam int DB = 4;
  localparam int RD = 16;
  localparam int RP = 8;
  localparam int BP = 4;

  logic       clk;
  logic       reset_n;
  logic       btn_up;
  logic       btn_dn;
  logic       breathe_en;
  logic [3:0] duty_out;
  logic       at_max;
  logic       at_min;
  logic       step_pulse;
  logic       mode_breathe;

  typedef struct {
    int edge_no;
    int duty;
  } step_t;

  step_t exp_q[$];
  step_t mon_e;
  int    vectors     = 0;
  int    miscompares = 0;
  int    cyc         = 0;
  int    md          = 0;

  pwm_duty_ctrl #(
    .CNT_W      (26),
    .DB_CYCLES  (DB),
    .RPT_DELAY  (RD),
    .RPT_PERIOD (RP),
    .BRTH_PERIOD(BP),
    .INIT_DUTY  (4'd0)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .btn_up      (btn_up),
    .btn_dn      (btn_dn),
    .breathe_en  (breathe_en),
    .duty_out    (duty_out),
    .at_max      (at_max),
    .at_min      (at_min),
    .step_pulse  (step_pulse),
    .mode_breathe(mode_breathe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic waitEdges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pushStep(input int x, input int d);
    step_t s;
    s.edge_no = x;
    s.duty    = d;
    exp_q.push_back(s);
  endtask

  // A press raised after edge r and dropped after edge f is accepted DB cycles after
  // it reaches the synchroniser output; the first step lands on edge r+DB+3, repeats
  // follow RD then every RP edges while the accepted level is still high.
  task automatic planPress(input bit up, input int r, input int f);
    int x;
    int nd;
    bit first;
    x     = r + DB + 3;
    first = 1'b1;
    while (x <= f + DB + 2) begin
      nd = up ? md + 1 : md - 1;
      if (nd > 15) nd = 15;
      if (nd < 0)  nd = 0;
      if (nd != md) begin
        pushStep(x, nd);
        md = nd;
      end
      x     = x + (first ? RD : RP);
      first = 1'b0;
    end
  endtask

  // Breathe raised after edge b enters the ramp on edge b+3; ticks every BP edges up to last.
  task automatic planBreathe(input int b, input int last);
    int x;
    bit going_up;
    x        = b + 3 + BP;
    going_up = 1'b1;
    while (x <= last) begin
      if (going_up) begin
        if (md == 15) begin
          going_up = 1'b0;
          md       = 14;
        end else begin
          md = md + 1;
        end
      end else begin
        if (md == 0) begin
          going_up = 1'b1;
          md       = 1;
        end else begin
          md = md - 1;
        end
      end
      pushStep(x, md);
      x = x + BP;
    end
  endtask

  // sel: 0 = up, 1 = down, 2 = both together.
  task automatic applyStimulus(input int sel, input int len, input int gap);
    int r;
    r = cyc;
    if ((len >= DB) && (sel != 2)) planPress(sel == 0, r, r + len);
    btn_up = (sel == 0) || (sel == 2);
    btn_dn = (sel == 1) || (sel == 2);
    waitEdges(len);
    btn_up = 1'b0;
    btn_dn = 1'b0;
    waitEdges(gap);
    checkOutput("pending_steps", exp_q.size(), 0);
  endtask

  task automatic runBreathe(input int len, input int settle);
    int b;
    b = cyc;
    planBreathe(b, b + len + 2);
    breathe_en = 1'b1;
    waitEdges(2);
    checkOutput("mode_before_entry", mode_breathe, 0);
    waitEdges(2);
    checkOutput("mode_in_breathe", mode_breathe, 1);
    waitEdges(len - 4);
    breathe_en = 1'b0;
    waitEdges(2);
    checkOutput("mode_before_exit", mode_breathe, 1);
    waitEdges(1);
    checkOutput("mode_after_exit", mode_breathe, 0);
    waitEdges(settle);
    checkOutput("breathe_final_duty", duty_out, md);
    checkOutput("pending_steps", exp_q.size(), 0);
  endtask

  // Every step_pulse must match the oldest planned step, including its edge number.
  always @(negedge clk) begin
    if (step_pulse === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_step: got step with duty %0d, expected none (edge %0d)",
                 duty_out, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("step_edge", cyc, mon_e.edge_no);
        checkOutput("step_duty", duty_out, mon_e.duty);
        checkOutput("step_at_max", at_max, (mon_e.duty == 15) ? 1 : 0);
        checkOutput("step_at_min", at_min, (mon_e.duty == 0) ? 1 : 0);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion (edge %0d)", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int b;
    int len;
    reset_n    = 1'b0;
    btn_up     = 1'b0;
    btn_dn     = 1'b0;
    breathe_en = 1'b0;
    waitEdges(3);
    checkOutput("rst_duty", duty_out, 0);
    checkOutput("rst_at_min", at_min, 1);
    checkOutput("rst_at_max", at_max, 0);
    checkOutput("rst_step", step_pulse, 0);
    checkOutput("rst_mode", mode_breathe, 0);
    #2 reset_n = 1'b1;
    waitEdges(2);
    md = 0;

    // Single debounced press, shorter than the repeat delay.
    applyStimulus(0, 12, 20);
    checkOutput("t1_duty", duty_out, 1);

    // Reset asserted mid-debounce discards the press.
    btn_up = 1'b1;
    waitEdges(3);
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_duty", duty_out, 0);
    checkOutput("midrst_at_min", at_min, 1);
    btn_up = 1'b0;
    md     = 0;
    #1 reset_n = 1'b1;
    waitEdges(20);
    checkOutput("midrst_after_duty", duty_out, 0);

    // Glitch rejection and simultaneous up/down from a non-zero duty.
    applyStimulus(0, 8, 20);
    applyStimulus(0, 8, 20);
    applyStimulus(1, 3, 20);
    applyStimulus(2, 10, 20);
    checkOutput("t2_duty", duty_out, 2);

    // Randomised presses of varied length.
    for (int i = 0; i < 8; i++) begin
      applyStimulus($urandom_range(0, 1), $urandom_range(DB, 50), 20);
    end

    // Auto-repeat up to saturation from 12.
    while (md < 12) applyStimulus(0, 6, 20);
    while (md > 12) applyStimulus(1, 6, 20);
    applyStimulus(0, 200, 20);
    checkOutput("t3_duty", duty_out, 15);
    checkOutput("t3_at_max", at_max, 1);

    // Breathe from 13 long enough to turn around at both ends.
    while (md > 13) applyStimulus(1, 6, 20);
    runBreathe(90 + $urandom_range(0, 7), 20);

    // Button held across breathe exit: no step until released and pressed again.
    b   = cyc;
    len = 60 + $urandom_range(0, 8);
    planBreathe(b, b + len + 2);
    breathe_en = 1'b1;
    waitEdges(len - 10);
    btn_up = 1'b1;
    waitEdges(10);
    breathe_en = 1'b0;
    waitEdges(30);
    checkOutput("t5_mode", mode_breathe, 0);
    checkOutput("t5_frozen", duty_out, md);
    btn_up = 1'b0;
    waitEdges(20);
    checkOutput("pending_steps", exp_q.size(), 0);
    b = md;
    applyStimulus(0, 8, 20);
    checkOutput("t5_repress", duty_out, (b == 15) ? 15 : b + 1);

    // Asynchronous reset in the middle of breathe mode.
    b   = cyc;
    len = $urandom_range(10, 40);
    planBreathe(b, b + len);
    breathe_en = 1'b1;
    waitEdges(len);
    @(negedge clk);
    #2;
    reset_n    = 1'b0;
    breathe_en = 1'b0;
    #1;
    checkOutput("t6_duty", duty_out, 0);
    checkOutput("t6_at_min", at_min, 1);
    checkOutput("t6_at_max", at_max, 0);
    checkOutput("t6_step", step_pulse, 0);
    checkOutput("t6_mode", mode_breathe, 0);
    checkOutput("pending_steps", exp_q.size(), 0);
    md = 0;
    #1 reset_n = 1'b1;
    waitEdges(12);
    checkOutput("t6_after_mode", mode_breathe, 0);
    checkOutput("t6_after_duty", duty_out, 0);
    checkOutput("t6_after_step", step_pulse, 0);

    checkOutput("final_pending", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
